// File: rtl/egress.sv
// ---------------------------------------------------------------------------
// egress -- frame inserter for the 64b/66b TX path.
//
// Encoded blocks from the TX encoder are forwarded to the SERDES with one
// cycle of latency. A request on the req_* handshake starts a frame:
//   - The frame header is written into the first idle slot after the request.
//   - 56-bit payload beats are then written into later idle slots.
// Non-idle traffic is never delayed or dropped. Frame blocks only ever
// replace idle slots, so frames fill the gaps in the existing stream.
//
// Handshakes (strict valid/ready): a transfer happens on a rising clk edge
// where valid and ready are both high. Valid must not depend on ready.
//   req_*  : req_ready is a registered output. It is high only in IDLE.
//   pld_*  : pld_ready is combinational. It is high in PLD when the incoming
//            encoder block is an idle slot.
//
// Optional feature: define EGRESS_STATS_EN to add the stat_frames and
// stat_blocks counters.
//
// Parameters
//   ADR_WIDTH  : total address width. req_src and req_dst are ADR_WIDTH/2 each.
//   DATA_WIDTH : block width. Only 64 is supported.
//   HDR_WIDTH  : sync header width.
//
// Ports
//   clk, rst        : clock, asynchronous active-high reset
//   enc_tx_data/hdr : block and sync header from the 64b/66b encoder
//   serdes_tx_*     : registered block and sync header to the SERDES
//   req_*           : frame request (type, src, dst, len)
//   pld_*           : payload stream, 56 bits per beat
//   tx_len_err      : one-cycle pulse when pld_last disagrees with the length
//   busy            : high while a frame is in progress
//   state_dbg       : current FSM state (0 IDLE, 1 HDR, 2 PLD)
//   stat_frames     : completed frames (only when EGRESS_STATS_EN is defined)
//   stat_blocks     : substituted blocks (only when EGRESS_STATS_EN is defined)
// ---------------------------------------------------------------------------
module egress #(
  parameter int ADR_WIDTH  = 40,
  parameter int DATA_WIDTH = 64,
  parameter int HDR_WIDTH  = 2,
  localparam int AW        = ADR_WIDTH / 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] enc_tx_data,
  input  logic [HDR_WIDTH-1:0]  enc_tx_hdr,
  output logic [DATA_WIDTH-1:0] serdes_tx_data,
  output logic [HDR_WIDTH-1:0]  serdes_tx_hdr,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_type,
  input  logic [AW-1:0]         req_src,
  input  logic [AW-1:0]         req_dst,
  input  logic [13:0]           req_len,
  input  logic                  pld_valid,
  output logic                  pld_ready,
  input  logic [DATA_WIDTH-9:0] pld_data,
  input  logic                  pld_last,
  output logic                  tx_len_err,
  output logic                  busy,
  output logic [1:0]            state_dbg
`ifdef EGRESS_STATS_EN
  ,
  output logic [31:0]           stat_frames,
  output logic [31:0]           stat_blocks
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_PLD  = 2'd2
  } state_t;

  localparam logic [DATA_WIDTH-1:0] IDLE_DATA = DATA_WIDTH'(8'h1e);
  localparam logic [HDR_WIDTH-1:0]  CTRL_HDR  = HDR_WIDTH'(2'b10);

  state_t                  state;
  logic [1:0]              type_q;
  logic [AW-1:0]           src_q;
  logic [AW-1:0]           dst_q;
  logic [13:0]             len_q;
  logic [13:0]             remaining;

  logic                    idle_slot;
  logic                    last_beat;
  logic                    hdr_emit;
  logic                    beat;
  logic                    sub_valid;
  logic                    frame_done;
  logic [DATA_WIDTH-1:0]   hdr_block;
  logic [DATA_WIDTH-1:0]   sub_data;

  assign state_dbg = state;

  always_comb begin
    idle_slot  = (enc_tx_hdr == CTRL_HDR) && (enc_tx_data == IDLE_DATA);
    last_beat  = (remaining <= 14'd7);
    pld_ready  = (state == S_PLD) && idle_slot;
    hdr_emit   = (state == S_HDR) && idle_slot;
    beat       = pld_valid && pld_ready;
    sub_valid  = hdr_emit || beat;
    // A zero-length frame ends with its header. Otherwise the frame ends
    // with the beat that consumes the last 1..7 bytes.
    frame_done = (hdr_emit && (len_q == 14'd0)) || (beat && last_beat);
    hdr_block  = {type_q, len_q, src_q, dst_q, 8'h1a};
    if (hdr_emit)
      sub_data = hdr_block;
    else
      sub_data = {pld_data, (last_beat ? 8'h1c : 8'h1b)};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      type_q         <= '0;
      src_q          <= '0;
      dst_q          <= '0;
      len_q          <= '0;
      remaining      <= '0;
      serdes_tx_data <= IDLE_DATA;
      serdes_tx_hdr  <= CTRL_HDR;
      req_ready      <= 1'b0;
      tx_len_err     <= 1'b0;
      busy           <= 1'b0;
    end else begin
      // Datapath: substitute into an idle slot, otherwise forward the block.
      if (sub_valid) begin
        serdes_tx_data <= sub_data;
        serdes_tx_hdr  <= CTRL_HDR;
      end else begin
        serdes_tx_data <= enc_tx_data;
        serdes_tx_hdr  <= enc_tx_hdr;
      end

      // The block type always follows the byte count. A mismatched pld_last
      // is only reported.
      tx_len_err <= beat && (pld_last != last_beat);

      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            type_q    <= req_type;
            src_q     <= req_src;
            dst_q     <= req_dst;
            len_q     <= req_len;
            state     <= S_HDR;
            req_ready <= 1'b0;
            busy      <= 1'b1;
          end else begin
            // Also covers the first cycle after reset is released.
            req_ready <= 1'b1;
          end
        end
        S_HDR: begin
          if (hdr_emit) begin
            remaining <= len_q;
            if (frame_done) begin
              state     <= S_IDLE;
              req_ready <= 1'b1;
              busy      <= 1'b0;
            end else begin
              state <= S_PLD;
            end
          end
        end
        S_PLD: begin
          if (beat) begin
            // Subtract 7 bytes per beat, stopping at zero.
            remaining <= last_beat ? 14'd0 : (remaining - 14'd7);
            if (frame_done) begin
              state     <= S_IDLE;
              req_ready <= 1'b1;
              busy      <= 1'b0;
            end
          end
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef EGRESS_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_frames <= '0;
      stat_blocks <= '0;
    end else begin
      if (frame_done) stat_frames <= stat_frames + 32'd1;
      if (sub_valid)  stat_blocks <= stat_blocks + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_egress.sv
// ---------------------------------------------------------------------------
// tb_egress -- directed testbench for egress.
// Inputs change on the falling clock edge. Registered outputs are sampled
// on the falling edge. Combinational pld_ready is sampled 1 ns after the
// inputs change.
// ---------------------------------------------------------------------------
module tb_egress;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] enc_tx_data;
  logic [1:0]  enc_tx_hdr;
  logic [63:0] serdes_tx_data;
  logic [1:0]  serdes_tx_hdr;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_type;
  logic [19:0] req_src;
  logic [19:0] req_dst;
  logic [13:0] req_len;
  logic        pld_valid;
  logic        pld_ready;
  logic [55:0] pld_data;
  logic        pld_last;
  logic        tx_len_err;
  logic        busy;
  logic [1:0]  state_dbg;
`ifdef EGRESS_STATS_EN
  logic [31:0] stat_frames;
  logic [31:0] stat_blocks;
`endif

  int errors = 0;
  int checks = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  egress dut (
    .clk            (clk),
    .rst            (rst),
    .enc_tx_data    (enc_tx_data),
    .enc_tx_hdr     (enc_tx_hdr),
    .serdes_tx_data (serdes_tx_data),
    .serdes_tx_hdr  (serdes_tx_hdr),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_type       (req_type),
    .req_src        (req_src),
    .req_dst        (req_dst),
    .req_len        (req_len),
    .pld_valid      (pld_valid),
    .pld_ready      (pld_ready),
    .pld_data       (pld_data),
    .pld_last       (pld_last),
    .tx_len_err     (tx_len_err),
    .busy           (busy),
    .state_dbg      (state_dbg)
`ifdef EGRESS_STATS_EN
    ,
    .stat_frames    (stat_frames),
    .stat_blocks    (stat_blocks)
`endif
  );

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    enc_tx_hdr  = 2'b10;
    enc_tx_data = 64'h000000000000001e;
  endtask

  task automatic set_block(input logic [1:0] h, input logic [63:0] d);
    enc_tx_hdr  = h;
    enc_tx_data = d;
  endtask

  task automatic set_beat(input logic v, input logic [55:0] d, input logic l);
    pld_valid = v;
    pld_data  = d;
    pld_last  = l;
  endtask

  // Presents a request for one cycle. Returns one falling edge after the
  // request was accepted. The encoder stream is left idle.
  task automatic request(input logic [1:0] t, input logic [19:0] s,
                         input logic [19:0] d, input logic [13:0] l);
    @(negedge clk);
    set_idle();
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL req_ready_before_accept: got %b expected 1", req_ready);
    end
    checks++;
    req_valid = 1'b1;
    req_type  = t;
    req_src   = s;
    req_dst   = d;
    req_len   = l;
    @(negedge clk);
    req_valid = 1'b0;
    if (busy !== 1'b1 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL accepted: busy=%b req_ready=%b expected busy=1 req_ready=0",
               busy, req_ready);
    end
    checks++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    req_type = '0;
    req_src = '0;
    req_dst = '0;
    req_len = '0;
    set_beat(1'b0, '0, 1'b0);
    set_idle();
    #12;
    if (serdes_tx_data !== 64'h1e || serdes_tx_hdr !== 2'b10) begin
      errors++;
      $display("FAIL reset_serdes: got %h/%b expected 1e/10", serdes_tx_data, serdes_tx_hdr);
    end
    checks++;
    if (req_ready !== 1'b0 || pld_ready !== 1'b0 || tx_len_err !== 1'b0 ||
        busy !== 1'b0 || state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL reset_ctrl: rr=%b pr=%b err=%b busy=%b st=%0d expected all 0",
               req_ready, pld_ready, tx_len_err, busy, state_dbg);
    end
    checks++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b expected 1", req_ready);
    end
    checks++;
  endtask

  // Frame with len=0: type 01, src 0x12345, dst 0x6789a.
  // Header fields: [63:62]=01, [61:48]=0, [47:28]=0x12345, [27:8]=0x6789a,
  // [7:0]=1a, which gives 0x4000_1234_5678_9a1a.
  task automatic test_hdr_only();
    request(2'b01, 20'h12345, 20'h6789a, 14'd0);
    @(negedge clk);
    if (serdes_tx_data !== 64'h4000_1234_5678_9a1a || serdes_tx_hdr !== 2'b10) begin
      errors++;
      $display("FAIL hdr_only_block: got %h/%b expected 4000123456789a1a/10",
               serdes_tx_data, serdes_tx_hdr);
    end
    checks++;
    if (busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL hdr_only_done: busy=%b rr=%b expected 0/1", busy, req_ready);
    end
    checks++;
    @(negedge clk);
    if (serdes_tx_data !== 64'h1e || serdes_tx_hdr !== 2'b10) begin
      errors++;
      $display("FAIL hdr_only_after: got %h/%b expected 1e/10", serdes_tx_data, serdes_tx_hdr);
    end
    checks++;
  endtask

  // Frame with len=10: type 10, src 0x0abcd, dst 0x01234.
  // The header is 0x800a_0abc_d012_341a.
  task automatic test_payload();
    request(2'b10, 20'h0abcd, 20'h01234, 14'd10);
    set_beat(1'b1, 56'h11111111111111, 1'b0);
    #1;
    if (pld_ready !== 1'b0) begin
      errors++;
      $display("FAIL payload_ready_in_hdr: got %b expected 0", pld_ready);
    end
    checks++;
    @(negedge clk);
    if (serdes_tx_data !== 64'h800a_0abc_d012_341a) begin
      errors++;
      $display("FAIL payload_hdr: got %h expected 800a0abcd012341a", serdes_tx_data);
    end
    checks++;
    #1;
    if (pld_ready !== 1'b1) begin
      errors++;
      $display("FAIL payload_ready_in_pld: got %b expected 1", pld_ready);
    end
    checks++;
    @(negedge clk);
    if (serdes_tx_data !== 64'h111111111111111b || tx_len_err !== 1'b0) begin
      errors++;
      $display("FAIL payload_beat1: got %h err=%b expected 111111111111111b err=0",
               serdes_tx_data, tx_len_err);
    end
    checks++;
    set_beat(1'b1, 56'h22222222222222, 1'b1);
    @(negedge clk);
    set_beat(1'b0, '0, 1'b0);
    if (serdes_tx_data !== 64'h222222222222221c || tx_len_err !== 1'b0) begin
      errors++;
      $display("FAIL payload_beat2: got %h err=%b expected 222222222222221c err=0",
               serdes_tx_data, tx_len_err);
    end
    checks++;
    if (busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL payload_done: busy=%b rr=%b expected 0/1", busy, req_ready);
    end
    checks++;
  endtask

  // Data blocks placed between idle slots pass through unchanged. The frame
  // (type 01, len 10, src 0, dst 0; header 0x400a_0000_0000_001a) fills the
  // idle slots around them.
  task automatic test_interleave();
    request(2'b01, 20'h0, 20'h0, 14'd10);
    set_block(2'b01, 64'hdeadbeef_cafef00d);
    set_beat(1'b1, 56'h33333333333333, 1'b0);
    @(negedge clk);
    if (serdes_tx_data !== 64'hdeadbeef_cafef00d || serdes_tx_hdr !== 2'b01) begin
      errors++;
      $display("FAIL interleave_data1: got %h/%b expected deadbeefcafef00d/01",
               serdes_tx_data, serdes_tx_hdr);
    end
    checks++;
    set_idle();
    @(negedge clk);
    if (serdes_tx_data !== 64'h400a_0000_0000_001a || serdes_tx_hdr !== 2'b10) begin
      errors++;
      $display("FAIL interleave_hdr: got %h/%b expected 400a00000000001a/10",
               serdes_tx_data, serdes_tx_hdr);
    end
    checks++;
    set_block(2'b01, 64'h0123456789abcdef);
    #1;
    if (pld_ready !== 1'b0) begin
      errors++;
      $display("FAIL interleave_ready_busy_slot: got %b expected 0", pld_ready);
    end
    checks++;
    @(negedge clk);
    if (serdes_tx_data !== 64'h0123456789abcdef || serdes_tx_hdr !== 2'b01) begin
      errors++;
      $display("FAIL interleave_data2: got %h/%b expected 0123456789abcdef/01",
               serdes_tx_data, serdes_tx_hdr);
    end
    checks++;
    set_idle();
    @(negedge clk);
    if (serdes_tx_data !== 64'h333333333333331b || serdes_tx_hdr !== 2'b10) begin
      errors++;
      $display("FAIL interleave_beat1: got %h/%b expected 333333333333331b/10",
               serdes_tx_data, serdes_tx_hdr);
    end
    checks++;
    set_beat(1'b1, 56'h44444444444444, 1'b1);
    @(negedge clk);
    set_beat(1'b0, '0, 1'b0);
    if (serdes_tx_data !== 64'h444444444444441c || busy !== 1'b0) begin
      errors++;
      $display("FAIL interleave_beat2: got %h busy=%b expected 444444444444441c busy=0",
               serdes_tx_data, busy);
    end
    checks++;
  endtask

  // len=10 with pld_last on the first beat. There is also an idle slot in
  // PLD with no payload. Type 11, src 0xfffff, dst 0x00001.
  // The header is 0xc00a_ffff_f000_011a.
  task automatic test_len_err();
    request(2'b11, 20'hfffff, 20'h00001, 14'd10);
    @(negedge clk);
    if (serdes_tx_data !== 64'hc00a_ffff_f000_011a) begin
      errors++;
      $display("FAIL len_err_hdr: got %h expected c00afffff000011a", serdes_tx_data);
    end
    checks++;
    @(negedge clk);
    if (serdes_tx_data !== 64'h1e || serdes_tx_hdr !== 2'b10 || busy !== 1'b1) begin
      errors++;
      $display("FAIL len_err_gap: got %h/%b busy=%b expected 1e/10 busy=1",
               serdes_tx_data, serdes_tx_hdr, busy);
    end
    checks++;
    set_beat(1'b1, 56'h55555555555555, 1'b1);
    @(negedge clk);
    if (serdes_tx_data !== 64'h555555555555551b || tx_len_err !== 1'b1) begin
      errors++;
      $display("FAIL len_err_beat1: got %h err=%b expected 555555555555551b err=1",
               serdes_tx_data, tx_len_err);
    end
    checks++;
    set_beat(1'b1, 56'h66666666666666, 1'b1);
    @(negedge clk);
    set_beat(1'b0, '0, 1'b0);
    if (serdes_tx_data !== 64'h666666666666661c || tx_len_err !== 1'b0) begin
      errors++;
      $display("FAIL len_err_beat2: got %h err=%b expected 666666666666661c err=0",
               serdes_tx_data, tx_len_err);
    end
    checks++;
  endtask

  // Reset while a frame is in progress.
  task automatic test_reset_mid_frame();
    request(2'b01, 20'h00abc, 20'h00def, 14'd20);
    @(negedge clk);
    set_beat(1'b1, 56'h77777777777777, 1'b0);
    rst = 1'b1;
    #1;
    if (serdes_tx_data !== 64'h1e || serdes_tx_hdr !== 2'b10 || busy !== 1'b0 ||
        req_ready !== 1'b0 || pld_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %h/%b busy=%b rr=%b pr=%b expected 1e/10 0 0 0",
               serdes_tx_data, serdes_tx_hdr, busy, req_ready, pld_ready);
    end
    checks++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    if (serdes_tx_data !== 64'h1e || req_ready !== 1'b1 || pld_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_after: got %h rr=%b pr=%b expected 1e rr=1 pr=0",
               serdes_tx_data, req_ready, pld_ready);
    end
    checks++;
    set_beat(1'b0, '0, 1'b0);
  endtask

`ifdef EGRESS_STATS_EN
  task automatic stat_frame(input logic [13:0] l, input int nb);
    request(2'b01, 20'h1, 20'h2, l);
    for (int b = 1; b <= nb; b++) begin
      @(negedge clk);
      set_beat(1'b1, 56'h0, (b == nb));
    end
    @(negedge clk);
    set_beat(1'b0, '0, 1'b0);
  endtask

  // Frames of length 0, 7 and 8 use 1 + 2 + 3 = 6 substituted blocks.
  task automatic test_stats();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    stat_frame(14'd0, 0);
    stat_frame(14'd7, 1);
    stat_frame(14'd8, 2);
    @(negedge clk);
    if (stat_frames !== 32'd3 || stat_blocks !== 32'd6) begin
      errors++;
      $display("FAIL stats: frames=%0d blocks=%0d expected 3/6", stat_frames, stat_blocks);
    end
    checks++;
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_hdr_only();
    test_payload();
    test_interleave();
    test_len_err();
    test_reset_mid_frame();
`ifdef EGRESS_STATS_EN
    test_stats();
`endif
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
